register_file: RTL and testbench



---
 rtl/register_file.sv | 31 +++
 tb/tb_register_file.sv | 92 +++++++++
 2 files changed

// File: rtl/register_file.sv
// register_file: 64x32 MIPS-style register file, two combinational read ports, one synchronous write port.
// Entry 0 has no storage and always reads zero; reset wins over a simultaneous write.
module register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  regwrite,
    input  logic [ADDR_WIDTH-1:0] read_reg1,
    input  logic [ADDR_WIDTH-1:0] read_reg2,
    input  logic [ADDR_WIDTH-1:0] write_reg,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic [DATA_WIDTH-1:0] read_data1,
    output logic [DATA_WIDTH-1:0] read_data2
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    logic [DATA_WIDTH-1:0] r_mem [1:DEPTH-1];
    logic                  w_we;
    assign w_we = regwrite && (write_reg != '0);
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 1; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_we) begin
            r_mem[write_reg] <= write_data;
        end
    end
    // No bypass: a same-cycle write becomes visible only after the edge.
    assign read_data1 = (read_reg1 == '0) ? '0 : r_mem[read_reg1];
    assign read_data2 = (read_reg2 == '0) ? '0 : r_mem[read_reg2];
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: randomized scoreboard bench for register_file against an array reference model.
// The driver queues the expected read values for each cycle; a negedge monitor pops and compares them.
module tb_register_file;
    logic        clk = 1'b0;
    logic        reset, regwrite;
    logic [5:0]  read_reg1, read_reg2, write_reg;
    logic [31:0] write_data, read_data1, read_data2;
    typedef struct {
        logic [5:0]  a, b;
        logic [31:0] e1, e2;
    } exp_t;
    exp_t        q[$];
    logic [31:0] model [64];
    int          n_chk = 0;
    int          n_fail = 0;
    register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(6)) dut (
        .clk(clk), .reset(reset), .regwrite(regwrite),
        .read_reg1(read_reg1), .read_reg2(read_reg2), .write_reg(write_reg),
        .write_data(write_data), .read_data1(read_data1), .read_data2(read_data2)
    );
    always #5 clk = ~clk;
    // Drive one cycle at posedge+1, queue the reads expected before the edge, then apply the write to the model.
    task automatic cyc(input logic rs, input logic we, input logic [5:0] wr, input logic [31:0] wd,
                       input logic [5:0] a, input logic [5:0] b, input bit chk = 1'b1);
        exp_t e;
        reset = rs; regwrite = we; write_reg = wr; write_data = wd;
        read_reg1 = a; read_reg2 = b;
        if (chk) begin
            e.a = a; e.b = b;
            e.e1 = (a == 0) ? 32'h0 : model[a];
            e.e2 = (b == 0) ? 32'h0 : model[b];
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        if (rs) begin
            for (int i = 0; i < 64; i++) model[i] = 32'h0;
        end else if (we && wr != 0) begin
            model[wr] = wd;
        end
    endtask
    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            n_chk++;
            if (read_data1 !== e.e1) begin
                n_fail++;
                $display("FAIL rd1[%0d] got %h expected %h", e.a, read_data1, e.e1);
            end
            n_chk++;
            if (read_data2 !== e.e2) begin
                n_fail++;
                $display("FAIL rd2[%0d] got %h expected %h", e.b, read_data2, e.e2);
            end
        end
    end
    initial begin
        for (int i = 0; i < 64; i++) model[i] = 32'hx;
        cyc(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 64; i++) cyc(0, 0, 0, 0, 6'(i), 6'(63 - i));
        cyc(0, 1, 0, 32'hFFFFFFFF, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 1, 4, 32'hFFFFFFFF, 4, 2);
        cyc(0, 0, 0, 0, 4, 2);
        cyc(0, 1, 1, 32'hFFFFFFFF, 1, 4);
        cyc(0, 0, 0, 0, 1, 4);
        repeat (3) cyc(0, 0, 5, 32'h12345678, 5, 1);
        cyc(0, 0, 0, 0, 5, 4);
        cyc(1, 1, 7, 32'hA5A5A5A5, 7, 1);
        cyc(0, 0, 0, 0, 7, 1);
        cyc(0, 0, 0, 0, 4, 5);
        cyc(0, 1, 63, 32'hA5A5A5A5, 63, 0);
        cyc(0, 0, 0, 0, 63, 63);
        for (int i = 0; i < 400; i++)
            cyc($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0, 6'($urandom), $urandom,
                6'($urandom), ($urandom_range(0, 7) == 0) ? 6'(0) : 6'($urandom));
        for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain pending %0d expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
    initial begin
        #100000;
        $display("FAIL timeout reached at %0t", $time);
        $fatal(1, "timeout");
    end
endmodule
